// File: rtl/ifetch_queue.sv
// Decoupled IF stage: owns the fetch PC, one outstanding bus request, DEPTH-entry instruction FIFO to ID.
// Latency: response accepted on data_ok appears at the FIFO head the following cycle (no bypass).
// Backpressure: out_ready stalls the head; a request is only issued while a free FIFO slot can be reserved.
module ifetch_queue #(
    parameter int                XLEN     = 64,
    parameter int                ILEN     = 32,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ireq_valid,
    output logic [XLEN-1:0]            ireq_addr,
    input  logic                       iresp_data_ok,
    input  logic [ILEN-1:0]            iresp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0]   req_pc, req_pc_nxt;
    logic [XLEN-1:0]   redir_al;
    entry_t            mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop;
    logic [CW-1:0]     occ_next;

    assign redir_al   = redirect_pc & ~XLEN'(3);
    assign ireq_valid = (state != IDLE);
    assign ireq_addr  = req_pc;
    assign out_valid  = (count != '0);
    assign out_pc     = mem[rd_ptr].pc;
    assign out_instr  = mem[rd_ptr].instr;

    // Redirect squashes both the response and any pop landing in the same cycle.
    assign push     = (state == BUSY) && iresp_data_ok && !redirect_valid;
    assign pop      = out_valid && out_ready && !redirect_valid;
    assign occ_next = count + CW'(push) - CW'(pop);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_pc_nxt   = req_pc;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redir_al;
                end else if (occ_next < DEPTH_C) begin
                    state_nxt    = BUSY;
                    req_pc_nxt   = fetch_pc;
                    fetch_pc_nxt = fetch_pc + XLEN'(4);
                end
            end
            BUSY: begin
                if (redirect_valid && iresp_data_ok) begin
                    req_pc_nxt   = redir_al;
                    fetch_pc_nxt = redir_al + XLEN'(4);
                end else if (redirect_valid) begin
                    state_nxt    = DROP;
                    fetch_pc_nxt = redir_al;
                end else if (iresp_data_ok) begin
                    if (occ_next < DEPTH_C) begin
                        req_pc_nxt   = fetch_pc;
                        fetch_pc_nxt = fetch_pc + XLEN'(4);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                // The stale response is swallowed; a same-cycle redirect picks the restart PC.
                if (iresp_data_ok) begin
                    state_nxt    = BUSY;
                    req_pc_nxt   = redirect_valid ? redir_al : fetch_pc;
                    fetch_pc_nxt = (redirect_valid ? redir_al : fetch_pc) + XLEN'(4);
                end else if (redirect_valid) begin
                    fetch_pc_nxt = redir_al;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: req_pc, instr: iresp_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= occ_next;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: per-cycle vector table, async reset mid-fetch, randomised streaming run.
module tb_ifetch_queue;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    ifetch_queue #(
        .XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h8000_0000)
    ) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [63:0] a);
        return a[31:0] ^ 32'h0013_0513 ^ {a[15:0], 16'h0000};
    endfunction

    assign iresp_data = model(ireq_addr);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        dok;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        e_ivld;
        logic [63:0] e_addr;
        logic        e_ovld;
        logic [63:0] e_opc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vec [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          popped;
        int          wait_cnt;
        int          cyc;
        logic [63:0] exp_pc;

        //        dok   rdy   rv    rpc               ivld  addr              ovld  opc               cnt
        vec[0]  = '{1'b1, 1'b1, 1'b0, 64'h0,            1'b1, 64'h8000_0000, 1'b0, 64'h0,           3'd0};
        vec[1]  = '{1'b1, 1'b1, 1'b0, 64'h0,            1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000, 3'd1};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 64'h0,            1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 3'd1};
        vec[3]  = '{1'b1, 1'b1, 1'b0, 64'h0,            1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008, 3'd1};
        vec[4]  = '{1'b1, 1'b0, 1'b0, 64'h0,            1'b1, 64'h8000_0010, 1'b1, 64'h8000_0008, 3'd2};
        vec[5]  = '{1'b1, 1'b0, 1'b0, 64'h0,            1'b1, 64'h8000_0014, 1'b1, 64'h8000_0008, 3'd3};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 64'h0,            1'b0, 64'h8000_0014, 1'b1, 64'h8000_0008, 3'd4};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 64'h0,            1'b0, 64'h8000_0014, 1'b1, 64'h8000_0008, 3'd4};
        vec[8]  = '{1'b0, 1'b1, 1'b0, 64'h0,            1'b1, 64'h8000_0018, 1'b1, 64'h8000_000C, 3'd3};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 64'h0,            1'b1, 64'h8000_0018, 1'b1, 64'h8000_000C, 3'd3};
        vec[10] = '{1'b0, 1'b1, 1'b1, 64'h8000_1002,    1'b1, 64'h8000_0018, 1'b0, 64'h0,           3'd0};
        vec[11] = '{1'b1, 1'b1, 1'b0, 64'h0,            1'b1, 64'h8000_1000, 1'b0, 64'h0,           3'd0};
        vec[12] = '{1'b1, 1'b1, 1'b0, 64'h0,            1'b1, 64'h8000_1004, 1'b1, 64'h8000_1000, 3'd1};
        vec[13] = '{1'b1, 1'b1, 1'b1, 64'h8000_2000,    1'b1, 64'h8000_2000, 1'b0, 64'h0,           3'd0};
        vec[14] = '{1'b1, 1'b1, 1'b0, 64'h0,            1'b1, 64'h8000_2004, 1'b1, 64'h8000_2000, 3'd1};

        reset          = 1'b0;
        iresp_data_ok  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b0;
        #23;
        chk("rst ireq_valid", {63'h0, ireq_valid}, 64'h0);
        chk("rst ireq_addr",  ireq_addr, 64'h8000_0000);
        chk("rst out_valid",  {63'h0, out_valid}, 64'h0);
        chk("rst out_pc",     out_pc, 64'h0);
        chk("rst out_instr",  {32'h0, out_instr}, 64'h0);
        chk("rst count",      {61'h0, count}, 64'h0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            iresp_data_ok  = vec[i].dok;
            out_ready      = vec[i].rdy;
            redirect_valid = vec[i].rv;
            redirect_pc    = vec[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ireq_valid", i), {63'h0, ireq_valid}, {63'h0, vec[i].e_ivld});
            chk($sformatf("v%0d ireq_addr", i),  ireq_addr, vec[i].e_addr);
            chk($sformatf("v%0d out_valid", i),  {63'h0, out_valid}, {63'h0, vec[i].e_ovld});
            chk($sformatf("v%0d count", i),      {61'h0, count}, {61'h0, vec[i].e_cnt});
            if (vec[i].e_ovld) begin
                chk($sformatf("v%0d out_pc", i),    out_pc, vec[i].e_opc);
                chk($sformatf("v%0d out_instr", i), {32'h0, out_instr}, {32'h0, model(vec[i].e_opc)});
            end
        end

        // Fill to three entries while BUSY, then drop reset between clock edges.
        redirect_valid = 1'b0;
        iresp_data_ok  = 1'b1;
        out_ready      = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("pre-rst count",      {61'h0, count}, 64'd3);
        chk("pre-rst ireq_valid", {63'h0, ireq_valid}, 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async ireq_valid", {63'h0, ireq_valid}, 64'h0);
        chk("async out_valid",  {63'h0, out_valid}, 64'h0);
        chk("async count",      {61'h0, count}, 64'h0);
        chk("async ireq_addr",  ireq_addr, 64'h8000_0000);

        iresp_data_ok = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("restart ireq_valid", {63'h0, ireq_valid}, 64'h1);
        chk("restart ireq_addr",  ireq_addr, 64'h8000_0000);

        // Streaming run: random consumer stalls and random 0-2 cycle bus latency.
        popped   = 0;
        exp_pc   = 64'h8000_0000;
        wait_cnt = $urandom_range(0, 2);
        cyc      = 0;
        while (popped < 20 && cyc < 2000) begin
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d out_pc", popped), out_pc, exp_pc);
                chk($sformatf("stream%0d out_instr", popped), {32'h0, out_instr}, {32'h0, model(exp_pc)});
                exp_pc = exp_pc + 64'd4;
                popped++;
            end
            if (ireq_valid && wait_cnt == 0) begin
                iresp_data_ok = 1'b1;
                wait_cnt      = $urandom_range(0, 2);
            end else begin
                iresp_data_ok = 1'b0;
                if (ireq_valid) wait_cnt--;
            end
            @(posedge clk);
            #1;
            total++;
            if (count > 3'd4) begin
                bad++;
                $display("FAIL stream count bound: got %0d want <=4", count);
            end
            cyc++;
        end
        chk("stream popped", 64'(popped), 64'd20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
